ddr3_iod_eye_training_ctrl: RTL

- Parametrised multi-lane read-eye training controller for the DDR3 PHY IOD lanes (BCLK/DQ training IODs in eye-monitor mode, dynamic delay line enabled).
- Trains one lane at a time:
  - Sweeps the lane's input delay line tap by tap and samples the IOD EYE_MONITOR_EARLY/LATE flags at each tap.
  - Finds the longest contiguous passing tap window, then parks the delay line at the window centre.
- Sits between the DDR training sequencer and NUM_LANES IOD instances; all IOD controls are driven in the FAB_CLK domain.

---
 rtl/ddr3_iod_train_pkg.sv | 36 +++
 rtl/ddr3_iod_train_window_tracker.sv | 51 +++++
 rtl/ddr3_iod_eye_training_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_iod_train_pkg.sv
// Shared types and constants for the DDR3 IOD read-eye training logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr3_iod_train_pkg;

    // Training controller states, in sweep order.
    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        EVAL,
        STEP,
        FINAL,
        CLOAD,
        CMOVE,
        NEXT,
        DONE_ST
    } train_state_t;

    // Settle/sample defaults, also used by the training sequencer.
    localparam int DEFAULT_SETTLE_CYCLES = 8;
    localparam int DEFAULT_SAMPLE_CYCLES = 16;

    // Bits needed to hold a tap index 0..tap_max.
    function automatic int tap_width(input int tap_max);
        return (tap_max < 1) ? 1 : $clog2(tap_max + 1);
    endfunction

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr3_iod_train_window_tracker.sv
// Tracks the longest contiguous run of passing taps and its centre tap.
// Latency: best_*/center update one cycle after a valid or close strobe.
// Backpressure: none; strobes are accepted every cycle.
module ddr3_iod_train_window_tracker
    import ddr3_iod_train_pkg::*;
#(
    parameter int  TAP_W = 7,
    localparam int LEN_W = TAP_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAP_W-1:0] tap,
    input  logic             pass,
    input  logic             valid,
    input  logic             clear,
    input  logic             close,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len,
    output logic [TAP_W-1:0] center
);

    logic [TAP_W-1:0] cur_start;
    logic [LEN_W-1:0] cur_len;
    logic [TAP_W-1:0] len_m1;

    // Extend the open run on pass; on fail or close keep it only if strictly longer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (valid && pass) begin
            if (cur_len == '0) begin
                cur_start <= tap;
            end
            cur_len <= cur_len + LEN_W'(1);
        end else if ((valid && !pass) || close) begin
            if (cur_len > best_len) begin
                best_start <= cur_start;
                best_len   <= cur_len;
            end
            cur_len <= '0;
        end
    end

    // A window never exceeds the tap range, so len-1 fits in TAP_W bits.
    assign len_m1 = TAP_W'(best_len - LEN_W'(1));
    assign center = (best_len != '0) ? (best_start + (len_m1 >> 1)) : '0;

endmodule

// File: rtl/ddr3_iod_eye_training_ctrl.sv
// Multi-lane read-eye trainer: sweeps each lane's delay line, parks it at the eye centre.
// Latency: per lane taps*(3+SETTLE+SAMPLE) + center + 4 cycles; lanes trained back to back.
// Backpressure: none; TRAIN_START is ignored while training is in progress.
module ddr3_iod_eye_training_ctrl
    import ddr3_iod_train_pkg::*;
#(
    parameter int  NUM_LANES     = 4,
    parameter int  TAP_MAX       = 127,
    parameter int  SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int  SAMPLE_CYCLES = DEFAULT_SAMPLE_CYCLES,
    parameter int  MIN_WINDOW    = 8,
    localparam int TAP_W         = tap_width(TAP_MAX)
) (
    input  logic                           FAB_CLK,
    input  logic                           RX_SYNC_RST,
    input  logic                           TRAIN_START,
    output logic                           TRAIN_BUSY,
    output logic                           TRAIN_DONE,
    output logic [NUM_LANES-1:0]           LANE_ERR,
    output logic [NUM_LANES*TAP_W-1:0]     CENTER_TAP,
    output logic [NUM_LANES*(TAP_W+1)-1:0] WINDOW_WIDTH,
    input  logic [NUM_LANES-1:0]           EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]           EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]           EYE_MONITOR_CLEAR_FLAGS,
    output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD
);

    localparam int LEN_W   = TAP_W + 1;
    localparam int LANE_W  = idx_width(NUM_LANES);
    localparam int CNT_W   = idx_width((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);

    localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(TAP_MAX);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [LEN_W-1:0]  MIN_LEN     = LEN_W'(MIN_WINDOW);

    train_state_t state;
    train_state_t state_nxt;

    logic [LANE_W-1:0]    lane_idx;
    logic [NUM_LANES-1:0] lane_sel;
    logic [TAP_W-1:0]     tap;
    logic [TAP_W-1:0]     move_cnt;
    logic [CNT_W-1:0]     cnt;
    logic                 fail_acc;
    logic                 oor_acc;
    logic                 busy;

    logic load_pls;
    logic clr_pls;
    logic move_pls;
    logic trk_clear;
    logic trk_valid;
    logic trk_close;

    logic [TAP_W-1:0] trk_best_start;
    logic [LEN_W-1:0] trk_best_len;
    logic [TAP_W-1:0] trk_center;
    logic             res_err;
    logic [TAP_W-1:0] res_center;

    logic [NUM_LANES-1:0] err_q;
    logic [TAP_W-1:0]     center_q [NUM_LANES];
    logic [LEN_W-1:0]     width_q  [NUM_LANES];

    // One tracker serves all lanes; it is cleared at the start of every lane sweep.
    ddr3_iod_train_window_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk        (FAB_CLK),
        .rst        (RX_SYNC_RST),
        .tap        (tap),
        .pass       (!fail_acc && !oor_acc),
        .valid      (trk_valid),
        .clear      (trk_clear),
        .close      (trk_close),
        .best_start (trk_best_start),
        .best_len   (trk_best_len),
        .center     (trk_center)
    );

    // A window narrower than MIN_WINDOW is unusable; park such a lane at tap 0.
    assign res_err    = (trk_best_len < MIN_LEN);
    assign res_center = res_err ? '0 : trk_center;

    assign lane_sel = NUM_LANES'(1) << lane_idx;
    assign busy     = (state != IDLE) && (state != DONE_ST);

    // State register.
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nxt = state;
        load_pls  = 1'b0;
        clr_pls   = 1'b0;
        move_pls  = 1'b0;
        trk_clear = 1'b0;
        trk_valid = 1'b0;
        trk_close = 1'b0;
        case (state)
            IDLE, DONE_ST: begin
                if (TRAIN_START) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_pls  = 1'b1;
                trk_clear = 1'b1;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_pls   = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                trk_valid = 1'b1;
                state_nxt = ((tap == TAP_LAST) || oor_acc) ? FINAL : STEP;
            end
            STEP: begin
                move_pls  = 1'b1;
                state_nxt = CLEAR;
            end
            FINAL: begin
                trk_close = 1'b1;
                state_nxt = CLOAD;
            end
            CLOAD: begin
                load_pls  = 1'b1;
                state_nxt = CMOVE;
            end
            CMOVE: begin
                if (move_cnt == res_center) begin
                    state_nxt = NEXT;
                end else begin
                    move_pls = 1'b1;
                end
            end
            NEXT: begin
                state_nxt = (lane_idx == LANE_LAST) ? DONE_ST : LOAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath: tap/lane counters, flag accumulation, per-lane result latching.
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            lane_idx <= '0;
            tap      <= '0;
            move_cnt <= '0;
            cnt      <= '0;
            fail_acc <= 1'b0;
            oor_acc  <= 1'b0;
            err_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                center_q[i] <= '0;
                width_q[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE_ST: begin
                    if (TRAIN_START) begin
                        lane_idx <= '0;
                        err_q    <= '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            center_q[i] <= '0;
                            width_q[i]  <= '0;
                        end
                    end
                end
                LOAD: begin
                    tap <= '0;
                end
                CLEAR: begin
                    cnt      <= '0;
                    fail_acc <= 1'b0;
                    oor_acc  <= 1'b0;
                end
                SETTLE: begin
                    cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    cnt      <= (cnt == SAMPLE_LAST) ? '0 : cnt + CNT_W'(1);
                    fail_acc <= fail_acc | (|((EYE_MONITOR_EARLY | EYE_MONITOR_LATE) & lane_sel));
                    oor_acc  <= oor_acc | (|(DELAY_LINE_OUT_OF_RANGE & lane_sel));
                end
                STEP: begin
                    tap <= tap + TAP_W'(1);
                end
                CLOAD: begin
                    move_cnt <= '0;
                end
                CMOVE: begin
                    if (move_cnt != res_center) begin
                        move_cnt <= move_cnt + TAP_W'(1);
                    end
                end
                NEXT: begin
                    err_q[lane_idx]    <= res_err;
                    center_q[lane_idx] <= res_center;
                    width_q[lane_idx]  <= trk_best_len;
                    if (lane_idx != LANE_LAST) begin
                        lane_idx <= lane_idx + LANE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The parked tap must always fall inside the reported window.
    assert property (@(posedge FAB_CLK) disable iff (RX_SYNC_RST)
        ((state == NEXT) && (trk_best_len != '0)) |-> (trk_center >= trk_best_start));

    // Strobes reach the active lane only; direction is held high for it while busy.
    assign EYE_MONITOR_CLEAR_FLAGS = lane_sel & {NUM_LANES{clr_pls}};
    assign DELAY_LINE_MOVE         = lane_sel & {NUM_LANES{move_pls}};
    assign DELAY_LINE_LOAD         = lane_sel & {NUM_LANES{load_pls}};
    assign DELAY_LINE_DIRECTION    = lane_sel & {NUM_LANES{busy}};

    assign TRAIN_BUSY = busy;
    assign TRAIN_DONE = (state == DONE_ST);
    assign LANE_ERR   = err_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_out
        assign CENTER_TAP[i*TAP_W +: TAP_W]   = center_q[i];
        assign WINDOW_WIDTH[i*LEN_W +: LEN_W] = width_q[i];
    end

endmodule
